// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished functional-unit result per cycle and broadcasts it
// one cycle later. Round-robin by default; define CDB_FIXED_PRIO_EN for lowest-index-wins.
module cdb_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TAGW = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 cdb_stall,
  input  logic                 flush,
  output logic                 cdb_valid,
  output logic [TAGW-1:0]      cdb_tag,
  output logic [31:0]          cdb_data
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] start, off, gnt_idx;
  logic [PtrW:0]   sum;
  logic [NREQ-1:0] rot;
  logic            found, xfer;
  logic [TAGW-1:0] sel_tag;
  logic [31:0]     sel_data;
  logic            cdb_valid_q;
  logic [TAGW-1:0] cdb_tag_q;
  logic [31:0]     cdb_data_q;

  // In the fixed-priority build ptr_q never leaves 0, so the scan always starts at index 0.
  assign start = ptr_q;

  // Rotate the request vector so the scan origin sits at bit 0, then find the first set bit.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> start);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = PtrW'(k);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (PtrW + 1)'(NREQ)) begin
      sum = sum - (PtrW + 1)'(NREQ);
    end
    gnt_idx = sum[PtrW-1:0];
  end

  always_comb begin
    xfer      = found & ~cdb_stall & ~flush & ~reset;
    req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;
    sel_tag   = req_tag[gnt_idx*TAGW +: TAGW];
    sel_data  = req_data[gnt_idx*32 +: 32];
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef CDB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (xfer) begin
      ptr_d = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + PtrW'(1);
    end
`endif
  end

  // Tag 0 means "no producer": accept the result but never put it on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= xfer && (sel_tag != '0);
      if (xfer && (sel_tag != '0)) begin
        cdb_tag_q  <= sel_tag;
        cdb_data_q <= sel_data;
      end
      ptr_q <= ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
- REQ-001 Parameter NREQ, default 4: number of functional-unit requesters (ALU, load, store, branch), range 2..8.
- REQ-002 Parameter TAGW, default 4: reservation-station tag width; tag 0 is reserved for "no producer".
- REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004 Port reset, input, 1: asynchronous, active-high reset.
- REQ-005 Port req_valid, input, NREQ: requester i holds a finished result.
- REQ-006 Port req_tag, input, NREQ*TAGW: packed result tags, requester i at slice [i*TAGW +: TAGW].
- REQ-007 Port req_data, input, NREQ*32: packed 32-bit results, requester i at slice [i*32 +: 32].
- REQ-008 Port req_ready, output, NREQ: one-hot grant; requester i's result is accepted this cycle.
- REQ-009 Port cdb_stall, input, 1: downstream (ROB/register file) cannot accept a broadcast this cycle.
- REQ-010 Port flush, input, 1: branch mispredict; squash pending and in-flight broadcasts.
- REQ-011 Port cdb_valid, output, 1: registered broadcast valid.
- REQ-012 Port cdb_tag, output, TAGW: registered broadcast tag.
- REQ-013 Port cdb_data, output, 32: registered broadcast value.

Function
- REQ-014 Handshake: a transfer from requester i occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
- REQ-015 Handshake: a requester shall hold valid, tag and data stable until its transfer occurs.
- REQ-016 req_ready shall be combinational from req_valid, the priority pointer, cdb_stall and flush, and at most one bit shall be high per cycle.
- REQ-017 req_ready shall be all-zero when cdb_stall=1, when flush=1, or when req_valid=0.
- REQ-018 Grant selection: scan from index ptr upward, modulo NREQ; the first requester with req_valid set receives the grant.
- REQ-019 Pointer update: after a transfer from requester g, ptr shall become (g+1) mod NREQ; with no transfer, ptr shall hold.
- REQ-020 Latency: a transfer at edge k shall drive cdb_valid=1 with the captured tag and data during cycle k+1, for exactly one cycle.
- REQ-021 With no transfer at an edge, cdb_valid shall be 0 in the next cycle; cdb_tag and cdb_data shall hold their last values.
- REQ-022 A transfer carrying tag 0 is a protocol error: the result shall be accepted but not broadcast (cdb_valid=0).
- REQ-023 Fairness: with all NREQ requesters continuously valid and no stall, each shall be granted exactly once in every NREQ consecutive cycles.
- REQ-024 Flush at edge k: cdb_valid shall be 0 in cycle k+1, no transfer shall occur at edge k, and ptr shall hold.
- REQ-025 Flush and stall together: flush takes precedence; the behaviour is the same as REQ-024.
- REQ-026 cdb_stall shall not clear a cdb_valid that is already registered; the downstream samples it in the same cycle.

Reset
- REQ-027 Asserting reset shall immediately clear cdb_valid, cdb_tag, cdb_data and ptr to 0.
- REQ-028 While reset is asserted, req_ready shall be 0.
- REQ-029 Reset mid-operation shall discard any in-flight broadcast.
- REQ-030 After reset is released, the first grant shall follow REQ-018 with ptr=0.

Configuration
- REQ-031 Macro CDB_FIXED_PRIO_EN selects fixed priority: the lowest-index valid requester always wins and ptr is unused (held at 0).
- REQ-032 Without CDB_FIXED_PRIO_EN, the round-robin behaviour of REQ-018, REQ-019 and REQ-023 applies.
- REQ-033 All other behaviour shall be identical with and without the macro.

Verification
- REQ-034 Single request: req_valid=4'b0100, tag 5, data 0xDEADBEEF -> req_ready=4'b0100 in the same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF; ptr=3.
- REQ-035 All four requesters held valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 (fixed-priority build: 0 every cycle).
- REQ-036 Stall: requests 4'b0011 with cdb_stall=1 for 3 cycles -> req_ready=0 and cdb_valid=0 throughout; requester 0 is granted on the first cycle after the stall.
- REQ-037 Flush: flush=1 in the cycle of a valid request -> no transfer, cdb_valid=0 next cycle, requester still pending and granted the cycle after.
- REQ-038 Mid-operation reset: assert reset while cdb_valid=1 -> cdb_valid=0 immediately, without waiting for an edge; ptr=0.
- REQ-039 Tag 0: request with tag 0 -> req_ready pulses and ptr advances, but cdb_valid stays 0.
